// File: rtl/chapter3_pkg.sv
// rtl/chapter3_pkg.sv - shared types and limits for the minterm sweeper
package chapter3_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} sweep_state_t;

  // Settle counter is 4 bits wide, so SETTLE_CYCLES must stay within 1..15.
  localparam int MAX_SETTLE_CYCLES = 15;

endpackage

// File: rtl/sweep_capture.sv
// rtl/sweep_capture.sv - truth-table bitmap capture and ones counter for e
module sweep_capture #(
  parameter int N_IN = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN-1:0]       idx,
  input  logic                  wr,
  input  logic                  clr,
  input  logic                  e,
  input  logic                  f,
  output logic [(1<<N_IN)-1:0]  e_map,
  output logic [(1<<N_IN)-1:0]  f_map,
  output logic [N_IN:0]         e_ones
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      e_map  <= '0;
      f_map  <= '0;
      e_ones <= '0;
    end else if (wr) begin
      e_map[idx] <= e;
      f_map[idx] <= f;
      e_ones     <= e_ones + {{N_IN{1'b0}}, e};
    end
  end

endmodule

// File: rtl/minterm_sweeper.sv
// rtl/minterm_sweeper.sv - sweeps all (a,b,c) minterms with d held, captures e/f truth tables
module minterm_sweeper
  import chapter3_pkg::*;
#(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  d_en,
  input  logic                  e_in,
  input  logic                  f_in,
  output logic [N_IN-1:0]       abc_out,
  output logic                  d_out,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [(1<<N_IN)-1:0]  e_map,
  output logic [(1<<N_IN)-1:0]  f_map,
  output logic [N_IN:0]         e_ones
);

  localparam logic [3:0]      SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] LAST_IDX      = {N_IN{1'b1}};

  sweep_state_t state;
  logic [3:0]   settle_cnt;
  logic         cap_wr;
  logic         cap_clr;

  // Abort in the sampling cycle suppresses the capture, including the final minterm.
  assign cap_wr  = (state == SAMPLE) && !abort;
  assign cap_clr = (state == IDLE) && start;

  sweep_capture #(.N_IN(N_IN)) u_capture (
    .clk    (clk),
    .rst    (rst),
    .idx    (abc_out),
    .wr     (cap_wr),
    .clr    (cap_clr),
    .e      (e_in),
    .f      (f_in),
    .e_map  (e_map),
    .f_map  (f_map),
    .e_ones (e_ones)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      abc_out    <= '0;
      d_out      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SETTLE;
            abc_out    <= '0;
            d_out      <= d_en;
            aborted    <= 1'b0;
            settle_cnt <= SETTLE_RELOAD;
            busy       <= 1'b1;
          end
        end
        SETTLE: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (settle_cnt == 4'd0) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (abc_out == LAST_IDX) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            abc_out    <= abc_out + 1'b1;
            settle_cnt <= SETTLE_RELOAD;
            state      <= SETTLE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minterm_sweeper.sv
// tb/tb_minterm_sweeper.sv - self-checking bench for minterm_sweeper with a truth-table load
module tb_minterm_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, start3, abort, d_en;
  logic [7:0] tt, tt3;
  logic       e_in, f_in, e_in3, f_in3;
  logic [2:0] abc_out, abc_out3;
  logic       d_out, d_out3, busy, busy3, done, done3, aborted, aborted3;
  logic [7:0] e_map, f_map, e_map3, f_map3;
  logic [3:0] e_ones, e_ones3;

  // Load circuit: e is an arbitrary truth table of (a,b,c), f = e & d.
  assign e_in  = tt[abc_out];
  assign f_in  = e_in & d_out;
  assign e_in3 = tt3[abc_out3];
  assign f_in3 = e_in3 & d_out3;

  minterm_sweeper dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .d_en(d_en),
    .e_in(e_in), .f_in(f_in), .abc_out(abc_out), .d_out(d_out), .busy(busy),
    .done(done), .aborted(aborted), .e_map(e_map), .f_map(f_map), .e_ones(e_ones)
  );

  minterm_sweeper #(.N_IN(3), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(1'b0), .d_en(d_en),
    .e_in(e_in3), .f_in(f_in3), .abc_out(abc_out3), .d_out(d_out3), .busy(busy3),
    .done(done3), .aborted(aborted3), .e_map(e_map3), .f_map(f_map3), .e_ones(e_ones3)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One sweep on the default instance. abort_k: minterm whose SAMPLE is aborted (-1 none);
  // rst_edge: edge after start at which rst is sampled (-1 none); pulse: extra start pulses.
  task automatic sweep(input logic d, input logic [7:0] t, input int abort_k,
                       input int rst_edge, input bit pulse, input string tag);
    int         n;
    int         dones;
    int         done_edge;
    int         abort_edge;
    bit         d_ok;
    logic [7:0] mask, exp_e, exp_f;
    int         exp_dones, exp_ab;
    n = 0; dones = 0; done_edge = -1; d_ok = 1'b1;
    abort_edge = (abort_k >= 0) ? 2 * abort_k + 2 : -1;
    tt = t; d_en = d; start = 1'b1;
    step();
    start = 1'b0;
    d_en  = ~d;
    while (n < 40) begin
      if (pulse) start = (n == 4 || n == 8);
      abort = (n == abort_edge - 1);
      rst   = (n == rst_edge - 1);
      step();
      n++;
      if (done) begin
        dones++;
        if (done_edge < 0) done_edge = n;
      end
      if (busy && d_out !== d) d_ok = 1'b0;
      if (n == abort_edge) begin
        chk({tag, "_abort_busy"}, busy, 0);
        chk({tag, "_abort_flag"}, aborted, 1);
      end
      if (n == rst_edge)
        chk({tag, "_rst_zero"}, {abc_out, d_out, busy, done, aborted, e_map, f_map, e_ones}, 0);
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;

    mask      = (abort_k >= 0) ? 8'((1 << abort_k) - 1) : 8'hFF;
    exp_e     = (rst_edge > 0) ? 8'h00 : (t & mask);
    exp_f     = exp_e & {8{d}};
    exp_dones = (rst_edge > 0 || abort_k >= 0) ? 0 : 1;
    exp_ab    = (rst_edge < 0 && abort_k >= 0) ? 1 : 0;

    chk({tag, "_done_count"}, dones, exp_dones);
    if (exp_dones == 1) chk({tag, "_latency"}, done_edge, 16);
    chk({tag, "_e_map"}, e_map, exp_e);
    chk({tag, "_f_map"}, f_map, exp_f);
    chk({tag, "_e_ones"}, e_ones, $countones(exp_e));
    chk({tag, "_aborted"}, aborted, exp_ab);
    chk({tag, "_d_held"}, d_ok, 1);
  endtask

  initial begin
    int n3;
    int done3_edge;
    int seq_bad;
    int k;
    rst = 1'b1; start = 1'b0; start3 = 1'b0; abort = 1'b0; d_en = 1'b0;
    tt = 8'h00; tt3 = 8'h00;
    step(); step();
    chk("reset_dut", {abc_out, d_out, busy, done, aborted, e_map, f_map, e_ones}, 0);
    chk("reset_dut3", {abc_out3, d_out3, busy3, done3, aborted3, e_map3, f_map3, e_ones3}, 0);
    rst = 1'b0;
    step();

    sweep(1'b1, 8'hD5, -1, -1, 1'b0, "udp_d1");
    sweep(1'b0, 8'hD5, -1, -1, 1'b0, "udp_d0");
    sweep(1'b1, 8'hD5, -1, -1, 1'b1, "restart_ignored");
    sweep(1'b1, 8'hD5,  3, -1, 1'b0, "abort_m3");
    sweep(1'b1, 8'hD5, -1,  7, 1'b0, "rst_mid");
    sweep(1'b1, 8'hD5, -1, -1, 1'b0, "after_rst");
    sweep(1'b1, 8'hD5,  7, -1, 1'b0, "abort_final");

    repeat (6) begin
      k = $urandom_range(0, 11);
      sweep(1'($urandom), 8'($urandom), (k > 7) ? -1 : k, -1, 1'b0, "rnd");
    end

    // Longer settle: each minterm held SETTLE_CYCLES+1 = 4 cycles.
    tt3 = 8'hD5; d_en = 1'b1; start3 = 1'b1;
    step();
    start3 = 1'b0;
    n3 = 0; done3_edge = -1; seq_bad = 0;
    while (n3 < 40) begin
      step();
      n3++;
      if (n3 < 32 && abc_out3 !== 3'(n3 / 4)) seq_bad++;
      if (done3 && done3_edge < 0) done3_edge = n3;
    end
    chk("s3_abc_sequence", seq_bad, 0);
    chk("s3_latency", done3_edge, 32);
    chk("s3_e_map", e_map3, 8'hD5);
    chk("s3_f_map", f_map3, 8'hD5);
    chk("s3_e_ones", e_ones3, 5);
    chk("s3_aborted", aborted3, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
